// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain stage.
//   fso_state_e : output-buffer occupancy state (EMPTY / ONE / TWO)
//   FSO_STAT_W  : width of the optional statistics counters
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fso_state_e;

  localparam int unsigned FSO_STAT_W = 32;

endpackage

// File: rtl/fso_burst_cnt.sv
// Beat-position counter for fixed-length bursts.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   clr       : return to the first beat (has priority over inc)
//   inc       : advance one beat, wrapping after LEN-1
//   valid     : qualifies the last decode
//   bcnt      : current beat index
//   last      : valid && bcnt is the final beat of the burst
module fso_burst_cnt #(
  parameter int unsigned LEN = 4,
  parameter int unsigned CW  = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          inc,
  input  logic          valid,
  output logic [CW-1:0] bcnt,
  output logic          last
);

  localparam logic [CW-1:0] MAX = CW'(LEN - 1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bcnt <= '0;
    end else if (clr) begin
      bcnt <= '0;
    end else if (inc) begin
      bcnt <= (bcnt == MAX) ? '0 : bcnt + 1'b1;
    end
  end

  assign last = valid && (bcnt == MAX);

endmodule

// File: rtl/fifo_stream_out.sv
// Read-side drain stage for a show-ahead FIFO. Pops words into a two-slot
// buffer and presents them as a valid/ready stream with m_last every
// BURST_LEN beats. fifo_pop depends only on registered occupancy, never on
// m_ready, so consumer backpressure does not reach the FIFO combinationally.
// Ports:
//   clk, rstn           : clock, synchronous active-low reset
//   fifo_dout/empty/pop : FIFO read port (head word valid when !fifo_empty)
//   flush               : drop buffered words and restart burst position
//   m_valid/ready/data  : output stream, m_data is the head slot
//   m_last              : final beat of the current burst
// Optional (define FIFO_STREAM_OUT_STATS_EN):
//   stat_beats          : count of accepted beats
//   stat_stalls         : count of cycles with m_valid && !m_ready
module fifo_stream_out
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4,
  parameter int BCNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
`ifdef FIFO_STREAM_OUT_STATS_EN
  ,
  output logic [FSO_STAT_W-1:0] stat_beats,
  output logic [FSO_STAT_W-1:0] stat_stalls
`endif
);

  fso_state_e       state, state_nxt;
  logic [WIDTH-1:0] slot0, slot1;
  logic [WIDTH-1:0] slot0_nxt, slot1_nxt;
  logic             acc;
  logic [BCNT_W-1:0] bcnt;

  assign fifo_pop = !fifo_empty && (state != TWO) && !flush && rstn;
  assign m_valid  = (state != EMPTY);
  assign acc      = m_valid && m_ready;
  assign m_data   = slot0;

  always_comb begin
    state_nxt = state;
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (fifo_pop) begin
            state_nxt = ONE;
            slot0_nxt = fifo_dout;
          end
        end
        ONE: begin
          if (fifo_pop && !acc) begin
            state_nxt = TWO;
            slot1_nxt = fifo_dout;
          end else if (fifo_pop && acc) begin
            slot0_nxt = fifo_dout;
          end else if (acc) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (acc) begin
            state_nxt = ONE;
            slot0_nxt = slot1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      state <= state_nxt;
      slot0 <= slot0_nxt;
      slot1 <= slot1_nxt;
    end
  end

  // Clear on flush wins over an accept in the same cycle, so a flush-cycle
  // transfer never advances the burst position.
  fso_burst_cnt #(
    .LEN (BURST_LEN),
    .CW  (BCNT_W)
  ) u_burst_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush),
    .inc   (acc),
    .valid (m_valid),
    .bcnt  (bcnt),
    .last  (m_last)
  );

`ifdef FIFO_STREAM_OUT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (acc)                 stat_beats  <= stat_beats + 1'b1;
      if (m_valid && !m_ready) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule
